game_state_ctl: RTL and testbench

- Parametrised game-flow controller for the Pacman top level; takes over the timing and game-rule work the top level does not yet do.
- Generates the gameplay tick and detects Pacman/monster collisions for NUM_MONSTERS monsters.
- Runs the IDLE/PLAY/DYING/OVER state machine and keeps the lives count and a BCD score for the seven-segment display.
- Sits between the movement blocks (pacman, monster) and the graphic and score-display blocks.

---
 rtl/game_state_ctl.sv | 262 ++++++++++++++++++++++++++
 tb/tb_game_state_ctl.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/game_state_ctl.sv
// Game-flow controller: gameplay tick, Pacman/monster collision, IDLE/PLAY/DYING/OVER
// sequencing, lives and saturating BCD score. Define FRIGHT_EN to enable the fright mode.
module game_state_ctl #(
    parameter int NUM_MONSTERS = 3,
    parameter int COORD_W      = 9,
    parameter int SCORE_DIGITS = 4,
    parameter int LIVES        = 3,
    parameter int TICK_DIV     = 100000,
    parameter int DEATH_TICKS  = 1000,
    parameter int HIT_DIST     = 8
) (
    input  logic                             i_clk,
    input  logic                             i_rst_n,
    input  logic [3:0]                       i_btn,
    input  logic [COORD_W-1:0]               i_p_x,
    input  logic [COORD_W-1:0]               i_p_y,
    input  logic [NUM_MONSTERS*COORD_W-1:0]  i_m_x,
    input  logic [NUM_MONSTERS*COORD_W-1:0]  i_m_y,
    input  logic                             i_pellet_eaten,
    input  logic                             i_power_eaten,
    output logic                             o_tick,
    output logic                             o_move_en,
    output logic                             o_respawn,
    output logic [1:0]                       o_state,
    output logic [2:0]                       o_lives,
    output logic [4*SCORE_DIGITS-1:0]        o_score,
    output logic                             o_fright
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_DYING = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = (DEATH_TICKS > 1) ? $clog2(DEATH_TICKS) : 1;
    localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEATH_LAST = DW'(DEATH_TICKS - 1);
    localparam logic [COORD_W:0] HIT_LIM = (COORD_W+1)'(HIT_DIST);
    localparam logic [2:0] LIVES_INIT = 3'(LIVES);
    localparam logic [4*SCORE_DIGITS-1:0] SCORE_MAX = {SCORE_DIGITS{4'h9}};
    localparam bit LOST_TENS = (SCORE_DIGITS < 2);
    localparam bit LOST_HUND = (SCORE_DIGITS < 3);

    logic [TW-1:0]               r_tick_cnt;
    logic                        r_tick;
    logic [3:0]                  r_btn_prev;
    logic                        r_armed;
    logic [NUM_MONSTERS-1:0]     w_hit_vec;
    logic [NUM_MONSTERS-1:0]     r_hit_vec;
    logic                        w_hit_any;
    logic                        w_start;
    logic                        w_deadly;
    logic                        w_eat;
    logic                        w_fright;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [2:0]                  r_lives;
    logic [2:0]                  w_lives_next;
    logic [4*SCORE_DIGITS-1:0]   r_score;
    logic [4*SCORE_DIGITS-1:0]   w_score_next;
    logic                        r_respawn;
    logic                        w_respawn_next;
    logic [DW-1:0]               r_death_cnt;
    logic [DW-1:0]               w_death_next;

    logic [3:0]                  w_tens_add;
    logic [3:0]                  w_hund_add;
    logic [3:0]                  w_dig_add;
    logic [4:0]                  w_bcd_sum;
    logic                        w_bcd_carry;
    logic                        w_bcd_ovf;
    logic [4*SCORE_DIGITS-1:0]   w_score_add;
    logic [4*SCORE_DIGITS-1:0]   w_score_sum;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b0;
        end else if (r_tick_cnt == TICK_LAST) begin
            r_tick_cnt <= '0;
            r_tick     <= 1'b1;
        end else begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            r_tick     <= 1'b0;
        end
    end

    // r_armed masks the first cycle after reset so a button held through release is not a press.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_btn_prev <= 4'd0;
            r_armed    <= 1'b0;
        end else begin
            r_btn_prev <= i_btn;
            r_armed    <= 1'b1;
        end
    end

    assign w_start = r_armed && (r_btn_prev == 4'd0) && (i_btn != 4'd0);

    for (genvar g = 0; g < NUM_MONSTERS; g++) begin : g_hit
        logic [COORD_W-1:0] w_mx;
        logic [COORD_W-1:0] w_my;
        logic [COORD_W-1:0] w_dx;
        logic [COORD_W-1:0] w_dy;
        assign w_mx = i_m_x[g*COORD_W +: COORD_W];
        assign w_my = i_m_y[g*COORD_W +: COORD_W];
        assign w_dx = (i_p_x >= w_mx) ? (i_p_x - w_mx) : (w_mx - i_p_x);
        assign w_dy = (i_p_y >= w_my) ? (i_p_y - w_my) : (w_my - i_p_y);
        assign w_hit_vec[g] = ({1'b0, w_dx} < HIT_LIM) && ({1'b0, w_dy} < HIT_LIM);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hit_vec <= '0;
        end else begin
            r_hit_vec <= w_hit_vec;
        end
    end

    assign w_hit_any = |r_hit_vec;

`ifdef FRIGHT_EN
    localparam logic [12:0] FRIGHT_TICKS = 13'd5000;

    logic [12:0]             r_fright_cnt;
    logic [NUM_MONSTERS-1:0] r_eaten;
    logic [NUM_MONSTERS-1:0] w_new_eat;

    assign w_fright  = (r_fright_cnt != 13'd0);
    assign w_new_eat = r_hit_vec & ~r_eaten;
    assign w_eat     = w_fright && (w_new_eat != '0);
    // Any contact during fright is harmless; only not-yet-eaten monsters score.
    assign w_deadly  = w_fright ? 1'b0 : w_hit_any;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_fright_cnt <= 13'd0;
            r_eaten      <= '0;
        end else if (r_state == ST_PLAY && w_state_next == ST_DYING) begin
            r_fright_cnt <= 13'd0;
        end else if (r_state == ST_PLAY && i_power_eaten) begin
            r_fright_cnt <= FRIGHT_TICKS;
            r_eaten      <= '0;
        end else begin
            if (r_tick && w_fright) begin
                r_fright_cnt <= r_fright_cnt - 13'd1;
            end
            if (r_state == ST_PLAY && w_eat) begin
                r_eaten <= r_eaten | w_new_eat;
            end
        end
    end
`else
    assign w_fright = 1'b0;
    assign w_eat    = 1'b0;
    assign w_deadly = w_hit_any;
`endif

    assign w_tens_add = (i_pellet_eaten ? 4'd1 : 4'd0) + (i_power_eaten ? 4'd5 : 4'd0);
    assign w_hund_add = w_eat ? 4'd2 : 4'd0;

    // Single-cycle ripple BCD add; any carry out of the top digit clamps to all nines.
    always_comb begin
        w_bcd_carry = 1'b0;
        w_bcd_sum   = '0;
        w_dig_add   = '0;
        w_score_add = '0;
        for (int d = 0; d < SCORE_DIGITS; d++) begin
            w_dig_add = (d == 1) ? w_tens_add : ((d == 2) ? w_hund_add : 4'd0);
            w_bcd_sum = {1'b0, r_score[4*d +: 4]} + {1'b0, w_dig_add} + {4'd0, w_bcd_carry};
            if (w_bcd_sum > 5'd9) begin
                w_score_add[4*d +: 4] = 4'(w_bcd_sum - 5'd10);
                w_bcd_carry           = 1'b1;
            end else begin
                w_score_add[4*d +: 4] = w_bcd_sum[3:0];
                w_bcd_carry           = 1'b0;
            end
        end
        w_bcd_ovf   = w_bcd_carry || (LOST_TENS && (w_tens_add != 4'd0))
                                  || (LOST_HUND && (w_hund_add != 4'd0));
        w_score_sum = w_bcd_ovf ? SCORE_MAX : w_score_add;
    end

    always_comb begin
        w_state_next   = r_state;
        w_lives_next   = r_lives;
        w_score_next   = r_score;
        w_respawn_next = 1'b0;
        w_death_next   = r_death_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_start) begin
                    w_state_next   = ST_PLAY;
                    w_score_next   = '0;
                    w_lives_next   = LIVES_INIT;
                    w_respawn_next = 1'b1;
                end
            end
            ST_PLAY: begin
                w_score_next = w_score_sum;
                if (w_deadly && (r_lives != 3'd0)) begin
                    w_state_next = ST_DYING;
                    w_lives_next = r_lives - 3'd1;
                    w_death_next = '0;
                end
            end
            ST_DYING: begin
                if (r_tick) begin
                    if (r_death_cnt == DEATH_LAST) begin
                        w_death_next = '0;
                        if (r_lives == 3'd0) begin
                            w_state_next = ST_OVER;
                        end else begin
                            w_state_next   = ST_PLAY;
                            w_respawn_next = 1'b1;
                        end
                    end else begin
                        w_death_next = r_death_cnt + 1'b1;
                    end
                end
            end
            ST_OVER: begin
                if (w_start) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= ST_IDLE;
            r_lives     <= LIVES_INIT;
            r_score     <= '0;
            r_respawn   <= 1'b0;
            r_death_cnt <= '0;
        end else begin
            r_state     <= w_state_next;
            r_lives     <= w_lives_next;
            r_score     <= w_score_next;
            r_respawn   <= w_respawn_next;
            r_death_cnt <= w_death_next;
        end
    end

    assign o_tick    = r_tick;
    assign o_move_en = (r_state == ST_PLAY);
    assign o_respawn = r_respawn;
    assign o_state   = r_state;
    assign o_lives   = r_lives;
    assign o_score   = r_score;
    assign o_fright  = w_fright;

endmodule

// File: tb/tb_game_state_ctl.sv
// Directed bench for game_state_ctl with a short tick (4), death delay (3 ticks) and 2 lives.
module tb_game_state_ctl;

    localparam int CW = 9;
    localparam int NM = 3;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [3:0]           btn;
    logic [CW-1:0]        px;
    logic [CW-1:0]        py;
    logic [NM*CW-1:0]     mx;
    logic [NM*CW-1:0]     my;
    logic                 pellet;
    logic                 power;
    logic                 tick;
    logic                 moveEn;
    logic                 respawn;
    logic [1:0]           state;
    logic [2:0]           lives;
    logic [15:0]          score;
    logic                 fright;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    game_state_ctl #(
        .NUM_MONSTERS(NM), .COORD_W(CW), .SCORE_DIGITS(4), .LIVES(2),
        .TICK_DIV(4), .DEATH_TICKS(3), .HIT_DIST(8)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
        .i_p_x(px), .i_p_y(py), .i_m_x(mx), .i_m_y(my),
        .i_pellet_eaten(pellet), .i_power_eaten(power),
        .o_tick(tick), .o_move_en(moveEn), .o_respawn(respawn),
        .o_state(state), .o_lives(lives), .o_score(score), .o_fright(fright)
    );

    typedef struct {
        logic [3:0]  btn;
        logic        pellet;
        logic        power;
        int          m2x;
        int          m2y;
        logic [1:0]  expState;
        logic [2:0]  expLives;
        logic [15:0] expScore;
        logic        expRespawn;
        logic        expMoveEn;
    } vec_t;

    vec_t vecs[13];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic setMonster(input int idx, input int x, input int y);
        mx[idx*CW +: CW] = CW'(x);
        my[idx*CW +: CW] = CW'(y);
    endtask

    task automatic applyStimulus(input vec_t v);
        btn    = v.btn;
        pellet = v.pellet;
        power  = v.power;
        setMonster(2, v.m2x, v.m2y);
        @(negedge clk);
    endtask

    // Called at the first sample point inside DYING; counts ticks until the state leaves DYING.
    task automatic waitDying(output int ticksSeen);
        ticksSeen = int'(tick);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (state != 2'd2) return;
            ticksSeen += int'(tick);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int dyTicks;

        vecs[0]  = '{4'h0, 1'b0, 1'b0, 300, 300, 2'd0, 3'd2, 16'h0000, 1'b0, 1'b0};
        vecs[1]  = '{4'h1, 1'b0, 1'b0, 300, 300, 2'd1, 3'd2, 16'h0000, 1'b1, 1'b1};
        vecs[2]  = '{4'h0, 1'b0, 1'b0, 300, 300, 2'd1, 3'd2, 16'h0000, 1'b0, 1'b1};
        vecs[3]  = '{4'h0, 1'b1, 1'b0, 300, 300, 2'd1, 3'd2, 16'h0010, 1'b0, 1'b1};
        vecs[4]  = '{4'h0, 1'b1, 1'b0, 300, 300, 2'd1, 3'd2, 16'h0020, 1'b0, 1'b1};
        vecs[5]  = '{4'h0, 1'b1, 1'b0, 300, 300, 2'd1, 3'd2, 16'h0030, 1'b0, 1'b1};
        vecs[6]  = '{4'h0, 1'b1, 1'b1, 300, 300, 2'd1, 3'd2, 16'h0090, 1'b0, 1'b1};
        vecs[7]  = '{4'h2, 1'b0, 1'b0, 300, 300, 2'd1, 3'd2, 16'h0090, 1'b0, 1'b1};
        vecs[8]  = '{4'h0, 1'b0, 1'b0, 300, 300, 2'd1, 3'd2, 16'h0090, 1'b0, 1'b1};
        vecs[9]  = '{4'h0, 1'b0, 1'b0, 108, 100, 2'd1, 3'd2, 16'h0090, 1'b0, 1'b1};
        vecs[10] = '{4'h0, 1'b0, 1'b0, 108, 100, 2'd1, 3'd2, 16'h0090, 1'b0, 1'b1};
        vecs[11] = '{4'h0, 1'b0, 1'b0, 107,  93, 2'd1, 3'd2, 16'h0090, 1'b0, 1'b1};
        vecs[12] = '{4'h0, 1'b1, 1'b0, 300, 300, 2'd2, 3'd1, 16'h0100, 1'b0, 1'b0};

        rst_n  = 1'b0;
        btn    = 4'h0;
        pellet = 1'b0;
        power  = 1'b0;
        px     = CW'(100);
        py     = CW'(100);
        mx     = '0;
        my     = '0;
        setMonster(0, 10, 10);
        setMonster(1, 200, 200);
        setMonster(2, 300, 300);
        #12;
        @(negedge clk);
        rst_n = 1'b1;

        checkOutput("rst_state", state, 2'd0);
        checkOutput("rst_lives", lives, 3'd2);
        checkOutput("rst_score", score, 16'h0000);
        checkOutput("rst_tick", tick, 1'b0);
        checkOutput("rst_respawn", respawn, 1'b0);
        checkOutput("rst_move_en", moveEn, 1'b0);
        for (int n = 1; n <= 12; n++) begin
            @(negedge clk);
            checkOutput($sformatf("tick_cycle%0d", n), tick, (n % 4 == 0) ? 1'b1 : 1'b0);
        end

`ifdef FRIGHT_EN
        @(negedge clk);
        btn = 4'h1;
        @(negedge clk);
        checkOutput("fr_start", state, 2'd1);
        btn   = 4'h0;
        power = 1'b1;
        @(negedge clk);
        power = 1'b0;
        checkOutput("fr_power_score", score, 16'h0050);
        checkOutput("fr_flag", fright, 1'b1);
        setMonster(0, 100, 100);
        @(negedge clk);
        @(negedge clk);
        checkOutput("fr_eat_score", score, 16'h0250);
        checkOutput("fr_eat_state", state, 2'd1);
        checkOutput("fr_eat_flag", fright, 1'b1);
        repeat (3) @(negedge clk);
        checkOutput("fr_again_score", score, 16'h0250);
        checkOutput("fr_again_state", state, 2'd1);
`else
        // Button held across reset release must not start the game.
        rst_n = 1'b0;
        btn   = 4'h1;
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            checkOutput("held_btn_state", state, 2'd0);
        end

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_state", i), state, vecs[i].expState);
            checkOutput($sformatf("v%0d_lives", i), lives, vecs[i].expLives);
            checkOutput($sformatf("v%0d_score", i), score, vecs[i].expScore);
            checkOutput($sformatf("v%0d_respawn", i), respawn, vecs[i].expRespawn);
            checkOutput($sformatf("v%0d_move_en", i), moveEn, vecs[i].expMoveEn);
        end
        checkOutput("fright_off", fright, 1'b0);

        // Pellet held during DYING must be dropped.
        waitDying(dyTicks);
        pellet = 1'b0;
        checkOutput("dying1_ticks", dyTicks, 3);
        checkOutput("dying1_exit_state", state, 2'd1);
        checkOutput("dying1_respawn", respawn, 1'b1);
        checkOutput("dying1_lives", lives, 3'd1);
        checkOutput("dying1_score", score, 16'h0100);

        power = 1'b1;
        repeat (197) @(negedge clk);
        power  = 1'b0;
        pellet = 1'b1;
        repeat (4) @(negedge clk);
        pellet = 1'b0;
        checkOutput("preload_9990", score, 16'h9990);
        pellet = 1'b1;
        power  = 1'b1;
        @(negedge clk);
        checkOutput("sat_both", score, 16'h9999);
        power = 1'b0;
        @(negedge clk);
        pellet = 1'b0;
        checkOutput("sat_pellet", score, 16'h9999);

        setMonster(2, 107, 93);
        @(negedge clk);
        checkOutput("hit2_lat1_state", state, 2'd1);
        @(negedge clk);
        checkOutput("hit2_state", state, 2'd2);
        checkOutput("hit2_lives", lives, 3'd0);
        waitDying(dyTicks);
        setMonster(2, 300, 300);
        checkOutput("dying2_ticks", dyTicks, 3);
        checkOutput("over_state", state, 2'd3);
        checkOutput("over_lives", lives, 3'd0);
        checkOutput("over_score", score, 16'h9999);
        checkOutput("over_move_en", moveEn, 1'b0);
        checkOutput("over_respawn", respawn, 1'b0);

        btn = 4'h1;
        @(negedge clk);
        btn = 4'h0;
        checkOutput("over_to_idle", state, 2'd0);
        checkOutput("idle_score_held", score, 16'h9999);
        @(negedge clk);
        btn = 4'h8;
        @(negedge clk);
        btn = 4'h0;
        checkOutput("restart_state", state, 2'd1);
        checkOutput("restart_score", score, 16'h0000);
        checkOutput("restart_lives", lives, 3'd2);
        checkOutput("restart_respawn", respawn, 1'b1);

        pellet = 1'b1;
        @(negedge clk);
        pellet = 1'b0;
        rst_n  = 1'b0;
        #1;
        checkOutput("midreset_state", state, 2'd0);
        checkOutput("midreset_score", score, 16'h0000);
        checkOutput("midreset_lives", lives, 3'd2);
        checkOutput("midreset_move_en", moveEn, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
